// File: rtl/m72_cpu_bus_ctrl.sv
// M72 CPU bus controller: registers the V30 memory-cycle decode and arbitrates it onto the SDRAM CPU channel.
// Defining M72_CPU_BUS_HITCACHE_EN adds a one-entry read hit cache in front of the SDRAM channel.
module m72_cpu_bus_ctrl #(
    parameter logic [24:0] ROM_BASE       = 25'h0000000,
    parameter logic [24:0] RAM_BASE       = 25'h0100000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [15:0] UNMAPPED_DATA  = 16'hFFFF
) (
    input  logic        CLK_32M,
    input  logic        reset,
    input  logic [1:0]  memory_map,
    input  logic [19:0] cpu_addr,
    input  logic        cpu_mrq,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [1:0]  cpu_be,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_ready,
    output logic [23:0] sdr_addr,
    output logic        sdr_req,
    output logic        sdr_we,
    output logic [1:0]  sdr_be,
    output logic [15:0] sdr_data,
    input  logic        sdr_ack,
    input  logic [15:0] sdr_q,
    output logic        ev_unmapped,
    output logic        ev_wprot,
    output logic        timeout_flag
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    typedef enum logic [1:0] {RGN_NONE, RGN_ROM, RGN_RAM} region_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    region_t     region;
    logic [23:0] offset;
    logic [23:0] dec_addr;
    logic [15:0] tmo_cnt;
    logic        acc_read;
    logic        acc_write;
    logic        cache_hit;
    logic [15:0] hit_data;
    logic        unused_addr_lsb;

    // Byte address bit 0 never reaches the word-addressed SDRAM; lanes come from cpu_be.
    assign unused_addr_lsb = cpu_addr[0];
    assign acc_read        = cpu_rd;
    assign acc_write       = cpu_wr & ~cpu_rd;

    always_comb begin
        region = RGN_NONE;
        offset = '0;
        case (memory_map)
            2'd0: begin
                if (cpu_addr[19:18] == 2'b00 || cpu_addr[19:16] == 4'hF) begin
                    region = RGN_ROM;
                    offset = {7'd0, cpu_addr[17:1]};
                end else if (cpu_addr[19:17] == 3'b010) begin
                    region = RGN_RAM;
                    offset = {8'd0, cpu_addr[16:1]};
                end
            end
            2'd1, 2'd2: begin
                if (!cpu_addr[19] || cpu_addr[19:16] == 4'hF) begin
                    region = RGN_ROM;
                    offset = {6'd0, cpu_addr[18:1]};
                end else if ((memory_map == 2'd1 && cpu_addr[19:16] == 4'hA) ||
                             (memory_map == 2'd2 && cpu_addr[19:17] == 3'b100)) begin
                    region = RGN_RAM;
                    offset = {8'd0, cpu_addr[16:1]};
                end
            end
            default: begin
                region = RGN_NONE;
                offset = '0;
            end
        endcase
    end

    // Bases are region-aligned, so OR-ing in the offset is the same as adding it.
    assign dec_addr = ((region == RGN_ROM) ? ROM_BASE[24:1] : RAM_BASE[24:1]) | offset;

`ifdef M72_CPU_BUS_HITCACHE_EN
    logic        cache_valid;
    logic [23:0] cache_tag;
    logic [15:0] cache_data;
    logic [1:0]  map_q;
    logic        map_stable;

    assign map_stable = (memory_map == map_q);
    assign cache_hit  = cache_valid && map_stable && (region != RGN_NONE) && (dec_addr == cache_tag);
    assign hit_data   = cache_data;

    // A map change wins over a same-cycle fill so a stale word can never survive a remap.
    always_ff @(posedge CLK_32M) begin
        map_q <= memory_map;
        if (reset) begin
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            cache_data  <= '0;
        end else if (!map_stable) begin
            cache_valid <= 1'b0;
        end else if (state == IDLE && cpu_mrq && acc_write &&
                     region != RGN_NONE && dec_addr == cache_tag) begin
            cache_valid <= 1'b0;
        end else if (state == REQ && sdr_ack && !sdr_we) begin
            cache_valid <= 1'b1;
            cache_tag   <= sdr_addr;
            cache_data  <= sdr_q;
        end else if (state == REQ && !sdr_ack && tmo_cnt == TMO_LAST) begin
            cache_valid <= 1'b0;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign hit_data  = UNMAPPED_DATA;
`endif

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            cpu_din      <= UNMAPPED_DATA;
            cpu_ready    <= 1'b0;
            sdr_addr     <= '0;
            sdr_req      <= 1'b0;
            sdr_we       <= 1'b0;
            sdr_be       <= '0;
            sdr_data     <= '0;
            ev_unmapped  <= 1'b0;
            ev_wprot     <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            cpu_ready   <= 1'b0;
            ev_unmapped <= 1'b0;
            ev_wprot    <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_mrq && (acc_read || acc_write)) begin
                        if (region == RGN_NONE) begin
                            cpu_ready   <= 1'b1;
                            ev_unmapped <= 1'b1;
                            if (acc_read) cpu_din <= UNMAPPED_DATA;
                        end else if (acc_write && region == RGN_ROM) begin
                            cpu_ready <= 1'b1;
                            ev_wprot  <= 1'b1;
                        end else if (acc_read && cache_hit) begin
                            cpu_ready <= 1'b1;
                            cpu_din   <= hit_data;
                        end else begin
                            state    <= REQ;
                            tmo_cnt  <= '0;
                            sdr_req  <= 1'b1;
                            sdr_addr <= dec_addr;
                            sdr_we   <= acc_write;
                            sdr_be   <= cpu_be;
                            sdr_data <= cpu_dout;
                        end
                    end
                end
                REQ: begin
                    // An ack on the final allowed cycle still completes normally.
                    if (sdr_ack) begin
                        sdr_req <= 1'b0;
                        if (!sdr_we) cpu_din <= sdr_q;
                        state <= DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        sdr_req      <= 1'b0;
                        timeout_flag <= 1'b1;
                        cpu_din      <= UNMAPPED_DATA;
                        state        <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                DONE: begin
                    cpu_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
